// File: rtl/timeout_counter_bank_if.sv
// Control and status bundle for timeout_counter_bank.
// The master is the game controller and the slave is the counter bank.
//
// Signalling contract: there is no valid/ready pair on this bus. Every
// i_Start/i_Clear bit is a level that the slave samples on each rising clk_50M
// edge, and the slave never stalls. Holding i_Start high restarts the channel
// on every cycle. The i_Mode and i_Limit lanes only matter in a cycle where the
// matching i_Start bit is high. All o_* lanes are valid on every cycle.
// dbg_state exposes each channel's FSM state (2 bits per channel) so that
// checkers can bind to it.
interface timeout_counter_bank_if #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0]       i_Start;
  logic [CHANNELS-1:0]       i_Clear;
  logic [2*CHANNELS-1:0]     i_Mode;
  logic [CHANNELS*WIDTH-1:0] i_Limit;
  logic [CHANNELS*WIDTH-1:0] o_Count;
  logic [CHANNELS-1:0]       o_Busy;
  logic [CHANNELS-1:0]       o_Done;
  logic [CHANNELS-1:0]       o_Pulse;
  logic                      o_Tick;
  logic [2*CHANNELS-1:0]     dbg_state;

  modport master (
    output i_Start, i_Clear, i_Mode, i_Limit,
    input  o_Count, o_Busy, o_Done, o_Pulse, o_Tick, dbg_state
  );

  modport slave (
    input  i_Start, i_Clear, i_Mode, i_Limit,
    output o_Count, o_Busy, o_Done, o_Pulse, o_Tick, dbg_state
  );
endinterface

// File: rtl/timeout_counter_bank.sv
// Multi-channel timer/counter bank for the BlackJack controller.
// A shared prescaler produces a tick every PRESCALE clocks. Each channel is an
// IDLE/RUN/DONE machine that runs as a one-shot timeout, a periodic reload
// timer, or a free-running full-rate counter (used as the card seed).
// Priority inside each channel: reset > clear > start > count/tick.
module timeout_counter_bank #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 2,
  parameter int PRESCALE = 25000
) (
  input  logic                         clk_50M,
  input  logic                         i_Reset,
  timeout_counter_bank_if.slave        bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MD_ONESHOT  = 2'd0,
    MD_PERIODIC = 2'd1,
    MD_FREERUN  = 2'd2
  } mode_t;

  // The unused encoding 11 falls back to one-shot. Because of this, a latched
  // mode register never holds 11.
  function automatic mode_t decode_mode(input logic [1:0] m);
    mode_t r;
    case (m)
      2'b01:   r = MD_PERIODIC;
      2'b10:   r = MD_FREERUN;
      default: r = MD_ONESHOT;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q;
  logic          tick;

  // The tick is decoded from the registered prescaler, so it lines up exactly
  // with the cycle in which the prescaler shows PRESCALE-1.
  assign tick = (presc_q == PRESC_LAST);

  // Free-running prescaler. Only i_Reset affects it.
  always_ff @(posedge clk_50M) begin
    if (!i_Reset) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel state
  // ---------------------------------------------------------------------------
  state_t           state_q [CHANNELS];
  state_t           state_d [CHANNELS];
  mode_t            mode_q  [CHANNELS];
  mode_t            mode_d  [CHANNELS];
  logic [WIDTH-1:0] limit_q [CHANNELS];
  logic [WIDTH-1:0] limit_d [CHANNELS];
  logic [WIDTH-1:0] count_q [CHANNELS];
  logic [WIDTH-1:0] count_d [CHANNELS];
  logic             done_q  [CHANNELS];
  logic             done_d  [CHANNELS];
  logic             pulse_q [CHANNELS];
  logic             pulse_d [CHANNELS];

  // Channel registers. Reset returns every channel to IDLE with a zero count.
  always_ff @(posedge clk_50M) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (!i_Reset) begin
        state_q[c] <= ST_IDLE;
        mode_q[c]  <= MD_ONESHOT;
        limit_q[c] <= '0;
        count_q[c] <= '0;
        done_q[c]  <= 1'b0;
        pulse_q[c] <= 1'b0;
      end else begin
        state_q[c] <= state_d[c];
        mode_q[c]  <= mode_d[c];
        limit_q[c] <= limit_d[c];
        count_q[c] <= count_d[c];
        done_q[c]  <= done_d[c];
        pulse_q[c] <= pulse_d[c];
      end
    end
  end

  // Next-state logic per channel. Clear beats start, and start beats the tick.
  // The pulse is a strobe, so it defaults low every cycle.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      mode_d[c]  = mode_q[c];
      limit_d[c] = limit_q[c];
      count_d[c] = count_q[c];
      done_d[c]  = done_q[c];
      pulse_d[c] = 1'b0;

      if (bus.i_Clear[c]) begin
        state_d[c] = ST_IDLE;
        count_d[c] = '0;
        done_d[c]  = 1'b0;
      end else if (bus.i_Start[c]) begin
        // Mode and limit are captured only here. Later changes on the inputs
        // are invisible until the next start.
        state_d[c] = ST_RUN;
        mode_d[c]  = decode_mode(bus.i_Mode[2*c +: 2]);
        limit_d[c] = bus.i_Limit[c*WIDTH +: WIDTH];
        count_d[c] = '0;
        done_d[c]  = 1'b0;
      end else if (state_q[c] == ST_RUN) begin
        case (mode_q[c])
          MD_FREERUN: begin
            // Full clock rate. The count wraps naturally; flag the wrap.
            count_d[c] = count_q[c] + WIDTH'(1);
            pulse_d[c] = (count_q[c] == COUNT_MAX);
          end
          MD_PERIODIC: begin
            if (tick) begin
              if (count_q[c] == limit_q[c]) begin
                count_d[c] = '0;
                pulse_d[c] = 1'b1;
              end else begin
                count_d[c] = count_q[c] + WIDTH'(1);
              end
            end
          end
          default: begin
            // One-shot. The count holds at the limit once it expires.
            if (tick) begin
              if (count_q[c] == limit_q[c]) begin
                state_d[c] = ST_DONE;
                done_d[c]  = 1'b1;
                pulse_d[c] = 1'b1;
              end else begin
                count_d[c] = count_q[c] + WIDTH'(1);
              end
            end
          end
        endcase
      end
    end
  end

  // Pack the per-channel registers onto the output lanes.
  always_comb begin
    bus.o_Count   = '0;
    bus.o_Busy    = '0;
    bus.o_Done    = '0;
    bus.o_Pulse   = '0;
    bus.dbg_state = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      bus.o_Count[c*WIDTH +: WIDTH] = count_q[c];
      bus.o_Busy[c]                 = (state_q[c] == ST_RUN);
      bus.o_Done[c]                 = done_q[c];
      bus.o_Pulse[c]                = pulse_q[c];
      bus.dbg_state[2*c +: 2]       = state_q[c];
    end
    bus.o_Tick = tick;
  end

endmodule

// File: tb/tb_timeout_counter_bank.sv
// Directed bench for timeout_counter_bank with WIDTH=4, CHANNELS=2 and
// PRESCALE=4. The bench tracks the prescaler phase itself, so the cycles in
// which a tick is expected are known without reading the DUT.
module tb_timeout_counter_bank;
  localparam int W  = 4;
  localparam int CH = 2;
  localparam int PS = 4;

  // ---------------- clock / reset ----------------
  logic clk_50M = 1'b0;
  logic i_Reset = 1'b0;
  always #5 clk_50M = ~clk_50M;

  timeout_counter_bank_if #(.WIDTH(W), .CHANNELS(CH)) bus();

  timeout_counter_bank #(.WIDTH(W), .CHANNELS(CH), .PRESCALE(PS)) dut (
    .clk_50M (clk_50M),
    .i_Reset (i_Reset),
    .bus     (bus)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int ph    = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] cnt(input int c);
    logic [CH*W-1:0] all;
    all = bus.o_Count;
    return all[c*W +: W];
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one clock, then sample 1 ns after the edge.
  // The prescaler phase model is: cleared by reset, otherwise counting modulo PS.
  task automatic step();
    @(posedge clk_50M);
    #1;
    if (!i_Reset) ph = 0;
    else ph = (ph == PS-1) ? 0 : ph + 1;
    chk("tick", {31'b0, bus.o_Tick}, {31'b0, (ph == PS-1)});
  endtask

  // Advance until the current cycle is a tick cycle.
  task automatic to_tick();
    int guard;
    guard = 0;
    while (ph != PS-1 && guard < 2*PS) begin
      step();
      guard++;
    end
    chk("to_tick_bound", {31'b0, (ph == PS-1)}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e0;
    int p0;
    int p1;
    int last_p;
    bit tick_prev;
    logic [W-1:0] e1;

    bus.i_Start = '0;
    bus.i_Clear = '0;
    bus.i_Mode  = '0;
    bus.i_Limit = '0;
    i_Reset     = 1'b0;

    // Reset held for 3 cycles with random inputs: all outputs stay 0.
    for (int k = 0; k < 3; k++) begin
      bus.i_Start = 2'($urandom_range(0, 3));
      bus.i_Clear = 2'($urandom_range(0, 3));
      bus.i_Mode  = 4'($urandom_range(0, 15));
      bus.i_Limit = 8'($urandom_range(0, 255));
      step();
      chk("rst_count", bus.o_Count, 0);
      chk("rst_busy",  bus.o_Busy,  0);
      chk("rst_done",  bus.o_Done,  0);
      chk("rst_pulse", bus.o_Pulse, 0);
      chk("rst_state", bus.dbg_state, 0);
    end
    bus.i_Start = '0;
    bus.i_Clear = '0;
    bus.i_Mode  = '0;
    bus.i_Limit = '0;
    i_Reset     = 1'b1;

    // Release: the first tick appears in the 4th cycle after release.
    step();
    step();
    step();
    chk("first_tick", bus.o_Tick, 1);
    chk("idle_busy", bus.o_Busy, 0);

    // One-shot, limit 3.
    step();
    bus.i_Mode  = 4'b0000;
    bus.i_Limit = {4'd0, 4'd3};
    bus.i_Start = 2'b01;
    step();
    bus.i_Start = 2'b00;
    chk("os_busy", bus.o_Busy[0], 1);
    chk("os_cnt0", cnt(0), 0);
    chk("os_done0", bus.o_Done[0], 0);
    for (int k = 1; k <= 3; k++) begin
      to_tick();
      step();
      chk("os_cnt", cnt(0), k);
      chk("os_nodone", bus.o_Done[0], 0);
      chk("os_nopulse", bus.o_Pulse[0], 0);
    end
    to_tick();
    step();
    chk("os_exp_cnt", cnt(0), 3);
    chk("os_exp_done", bus.o_Done[0], 1);
    chk("os_exp_pulse", bus.o_Pulse[0], 1);
    chk("os_exp_busy", bus.o_Busy[0], 0);
    step();
    chk("os_pulse_low", bus.o_Pulse[0], 0);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("os_hold_cnt", cnt(0), 3);
      chk("os_hold_done", bus.o_Done[0], 1);
    end

    // Periodic limit 2 on ch0, free-run on ch1, started together.
    bus.i_Mode  = {2'b10, 2'b01};
    bus.i_Limit = {4'd0, 4'd2};
    bus.i_Start = 2'b11;
    step();
    bus.i_Start = 2'b00;
    chk("pf_busy", bus.o_Busy, 2'b11);
    chk("pf_cnt0", cnt(0), 0);
    chk("pf_cnt1", cnt(1), 0);
    e0 = 0;
    last_p = -1;
    for (int i = 1; i <= 40; i++) begin
      tick_prev = (ph == PS-1);
      step();
      p0 = 0;
      if (tick_prev) begin
        if (e0 == 2) begin
          e0 = 0;
          p0 = 1;
        end else begin
          e0++;
        end
      end
      exp_q.push_back(W'(i));
      p1 = (i % 16 == 0) ? 1 : 0;
      chk("per_cnt", cnt(0), e0);
      chk("per_pulse", bus.o_Pulse[0], p0);
      e1 = exp_q.pop_front();
      chk("fr_cnt", cnt(1), e1);
      chk("fr_pulse", bus.o_Pulse[1], p1);
      chk("pf_nodone", bus.o_Done, 0);
      if (p0 == 1) begin
        if (last_p >= 0) chk("per_interval", i - last_p, 12);
        last_p = i;
      end
    end

    // Restart at count 2, then the expiry is measured from the restart.
    bus.i_Mode  = {2'b10, 2'b00};
    bus.i_Limit = {4'd0, 4'd5};
    bus.i_Start = 2'b01;
    step();
    bus.i_Start = 2'b00;
    chk("rs_cnt0", cnt(0), 0);
    for (int k = 1; k <= 2; k++) begin
      to_tick();
      step();
      chk("rs_pre_cnt", cnt(0), k);
    end
    bus.i_Start = 2'b01;
    step();
    bus.i_Start = 2'b00;
    chk("rs_restart_cnt", cnt(0), 0);
    chk("rs_restart_busy", bus.o_Busy[0], 1);
    for (int k = 1; k <= 5; k++) begin
      to_tick();
      step();
      chk("rs_cnt", cnt(0), k);
      chk("rs_nodone", bus.o_Done[0], 0);
    end
    to_tick();
    step();
    chk("rs_done", bus.o_Done[0], 1);
    chk("rs_pulse", bus.o_Pulse[0], 1);
    chk("rs_hold", cnt(0), 5);

    // Start and clear together on ch0 (clear wins); plain clear on ch1.
    bus.i_Start = 2'b01;
    bus.i_Clear = 2'b11;
    step();
    bus.i_Start = 2'b00;
    bus.i_Clear = 2'b00;
    chk("clr_busy", bus.o_Busy, 0);
    chk("clr_count", bus.o_Count, 0);
    chk("clr_done", bus.o_Done, 0);
    chk("clr_state", bus.dbg_state, 0);

    // Limit 0, start coincident with a tick. ch1 uses mode 11, which acts as one-shot.
    to_tick();
    bus.i_Mode  = {2'b11, 2'b00};
    bus.i_Limit = 8'h00;
    bus.i_Start = 2'b11;
    step();
    bus.i_Start = 2'b00;
    chk("edge_busy", bus.o_Busy, 2'b11);
    chk("edge_nodone", bus.o_Done, 0);
    chk("edge_cnt", bus.o_Count, 0);
    bus.i_Limit = {4'd7, 4'd7};
    while (ph != PS-1) begin
      step();
      chk("edge_wait_nodone", bus.o_Done, 0);
    end
    step();
    chk("edge_done", bus.o_Done, 2'b11);
    chk("edge_pulse", bus.o_Pulse, 2'b11);
    chk("edge_cnt_hold", bus.o_Count, 0);
    chk("edge_idle", bus.o_Busy, 0);
    step();
    chk("edge_pulse_low", bus.o_Pulse, 0);

    // Reset in the middle of operation aborts every channel.
    bus.i_Mode  = {2'b10, 2'b01};
    bus.i_Start = 2'b11;
    step();
    bus.i_Start = 2'b00;
    step();
    step();
    i_Reset = 1'b0;
    step();
    chk("mrst_count", bus.o_Count, 0);
    chk("mrst_busy", bus.o_Busy, 0);
    chk("mrst_done", bus.o_Done, 0);
    chk("mrst_pulse", bus.o_Pulse, 0);
    chk("mrst_state", bus.dbg_state, 0);
    i_Reset = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Time bound for the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
